// File: rtl/cnn_kernel_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cnn_kernel_mac_pipe
// Brief    : Signed KXxKY window MAC with adder-tree reduction, accumulation
//            over CI input channels, bias, optional ReLU and output saturation.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_kernel_mac_pipe #(
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int CI     = 4,
    parameter int OUT_BW = 16,
    localparam int CH_BW = $clog2(CI) + ((CI == 1) ? 1 : 0)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_soft_reset,
    input  logic                       i_relu_en,
    input  logic [B_BW-1:0]            i_bias,
    input  logic                       i_in_valid,
    input  logic [KX*KY*I_F_BW-1:0]    i_in_fmap,
    input  logic [KX*KY*W_BW-1:0]      i_cnn_weight,
    output logic [CH_BW-1:0]           o_ch_idx,
    output logic                       o_ot_valid,
    output logic [OUT_BW-1:0]          o_ot_data
);

    localparam int NTAP    = KX * KY;
    localparam int MUL_BW  = I_F_BW + W_BW;
    localparam int SUM_BW  = MUL_BW + $clog2(NTAP);
    localparam int PRE_BW  = SUM_BW + $clog2(CI);
    localparam int ACC_BW  = ((PRE_BW > B_BW) ? PRE_BW : B_BW) + 1;

    localparam logic [CH_BW-1:0] c_last_ch = CH_BW'(CI - 1);

    // ------------------------------------------------------------------
    // Channel counter
    // ------------------------------------------------------------------
    logic [CH_BW-1:0] r_ch;
    logic             w_first;
    logic             w_last;

    assign w_first  = (r_ch == '0);
    assign w_last   = (r_ch == c_last_ch);
    assign o_ch_idx = r_ch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch <= '0;
        end else if (i_soft_reset) begin
            r_ch <= '0;
        end else if (i_in_valid) begin
            r_ch <= w_last ? '0 : r_ch + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // S1: element-wise signed products
    // ------------------------------------------------------------------
    logic signed [MUL_BW-1:0] w_mul [NTAP];
    logic signed [MUL_BW-1:0] r_mul [NTAP];
    logic                     r1_valid;
    logic                     r1_first;
    logic                     r1_last;
    logic signed [B_BW-1:0]   r1_bias;
    logic                     r1_relu;

    for (genvar n = 0; n < NTAP; n++) begin : g_tap
        assign w_mul[n] = MUL_BW'($signed(i_in_fmap[n*I_F_BW +: I_F_BW]))
                        * MUL_BW'($signed(i_cnn_weight[n*W_BW +: W_BW]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_valid <= 1'b0;
            r1_first <= 1'b0;
            r1_last  <= 1'b0;
            r1_bias  <= '0;
            r1_relu  <= 1'b0;
            for (int n = 0; n < NTAP; n++) r_mul[n] <= '0;
        end else if (i_soft_reset) begin
            r1_valid <= 1'b0;
            r1_first <= 1'b0;
            r1_last  <= 1'b0;
            r1_bias  <= '0;
            r1_relu  <= 1'b0;
            for (int n = 0; n < NTAP; n++) r_mul[n] <= '0;
        end else begin
            r1_valid <= i_in_valid;
            if (i_in_valid) begin
                r1_first <= w_first;
                r1_last  <= w_last;
                r1_bias  <= $signed(i_bias);
                r1_relu  <= i_relu_en;
                for (int n = 0; n < NTAP; n++) r_mul[n] <= w_mul[n];
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: adder-tree reduction (width grown so it can never overflow)
    // ------------------------------------------------------------------
    logic signed [SUM_BW-1:0] w_sum;
    logic signed [SUM_BW-1:0] r2_sum;
    logic                     r2_valid;
    logic                     r2_first;
    logic                     r2_last;
    logic signed [B_BW-1:0]   r2_bias;
    logic                     r2_relu;

    always_comb begin
        w_sum = '0;
        for (int n = 0; n < NTAP; n++) begin
            w_sum = w_sum + SUM_BW'(r_mul[n]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_valid <= 1'b0;
            r2_first <= 1'b0;
            r2_last  <= 1'b0;
            r2_bias  <= '0;
            r2_relu  <= 1'b0;
            r2_sum   <= '0;
        end else if (i_soft_reset) begin
            r2_valid <= 1'b0;
            r2_first <= 1'b0;
            r2_last  <= 1'b0;
            r2_bias  <= '0;
            r2_relu  <= 1'b0;
            r2_sum   <= '0;
        end else begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_first <= r1_first;
                r2_last  <= r1_last;
                r2_bias  <= r1_bias;
                r2_relu  <= r1_relu;
                r2_sum   <= w_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulate; the first beat of a group reloads with its own bias
    // so back-to-back groups never mix.
    // ------------------------------------------------------------------
    logic signed [ACC_BW-1:0] r_acc;
    logic signed [ACC_BW-1:0] w_acc_base;
    logic                     r3_done;
    logic                     r_grp_relu;

    assign w_acc_base = r2_first ? ACC_BW'(r2_bias) : r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            r3_done    <= 1'b0;
            r_grp_relu <= 1'b0;
        end else if (i_soft_reset) begin
            r_acc      <= '0;
            r3_done    <= 1'b0;
            r_grp_relu <= 1'b0;
        end else begin
            r3_done <= r2_valid && r2_last;
            if (r2_valid) begin
                r_acc <= w_acc_base + ACC_BW'(r2_sum);
                if (r2_first) begin
                    r_grp_relu <= r2_relu;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: ReLU on the finished group
    // ------------------------------------------------------------------
    logic signed [ACC_BW-1:0] r4_val;
    logic                     r4_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r4_val   <= '0;
            r4_valid <= 1'b0;
        end else if (i_soft_reset) begin
            r4_val   <= '0;
            r4_valid <= 1'b0;
        end else begin
            r4_valid <= r3_done;
            if (r3_done) begin
                r4_val <= (r_grp_relu && r_acc < 0) ? '0 : r_acc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output: saturate to OUT_BW and register; data holds between pulses
    // ------------------------------------------------------------------
    logic [OUT_BW-1:0] w_sat;

    if (ACC_BW > OUT_BW) begin : g_sat_narrow
        always_comb begin
            if (!r4_val[ACC_BW-1] && (|r4_val[ACC_BW-2:OUT_BW-1])) begin
                w_sat = {1'b0, {(OUT_BW-1){1'b1}}};
            end else if (r4_val[ACC_BW-1] && !(&r4_val[ACC_BW-2:OUT_BW-1])) begin
                w_sat = {1'b1, {(OUT_BW-1){1'b0}}};
            end else begin
                w_sat = r4_val[OUT_BW-1:0];
            end
        end
    end else begin : g_sat_wide
        assign w_sat = OUT_BW'(r4_val);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ot_valid <= 1'b0;
            o_ot_data  <= '0;
        end else if (i_soft_reset) begin
            o_ot_valid <= 1'b0;
            o_ot_data  <= '0;
        end else begin
            o_ot_valid <= r4_valid;
            if (r4_valid) begin
                o_ot_data <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire
